// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Optional ACCESS-phase timeout abort: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            rsp_slverr_o,
  output logic                            psel_o,
  output logic                            penable_o,
  output logic                            pwrite_o,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic [DATA_WIDTH-1:0]           pwdata_o,
  output logic [DATA_WIDTH/8-1:0]         pstrb_o,
  input  logic                            pready_i,
  input  logic                            pslverr_i,
  input  logic [DATA_WIDTH-1:0]           prdata_i
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] ptr, gnt, pick;
  logic [IW:0]   sum;
  logic          found;
  logic          done, abort;

  // First valid requester at or above ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ))
        sum = sum - (IW+1)'(NUM_REQ);
      if (!found && req_valid_i[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state == IDLE && found && !arst_i)
      req_ready_o[pick] = 1'b1;
  end

  assign done = (state == ACCESS) && pready_i;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  assign abort = (state == ACCESS) && !pready_i &&
                 (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Zero outside ACCESS, so it is clear on every ACCESS entry
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)
      cnt <= '0;
    else if (state != ACCESS)
      cnt <= '0;
    else if (!pready_i)
      cnt <= cnt + 1'b1;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (found) state_n = SETUP;
      SETUP:   state_n = ACCESS;
      ACCESS:  if (done || abort) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt          <= '0;
      psel_o       <= 1'b0;
      penable_o    <= 1'b0;
      pwrite_o     <= 1'b0;
      paddr_o      <= '0;
      pwdata_o     <= '0;
      pstrb_o      <= '0;
      rsp_valid_o  <= '0;
      rsp_rdata_o  <= '0;
      rsp_slverr_o <= 1'b0;
    end else begin
      state        <= state_n;
      psel_o       <= (state_n != IDLE);
      penable_o    <= (state_n == ACCESS);
      rsp_valid_o  <= '0;
      rsp_rdata_o  <= '0;
      rsp_slverr_o <= 1'b0;
      if (state == IDLE && found) begin
        gnt      <= pick;
        ptr      <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
        pwrite_o <= req_write_i[pick];
        paddr_o  <= req_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
        pwdata_o <= req_wdata_i[pick*DATA_WIDTH +: DATA_WIDTH];
        pstrb_o  <= req_write_i[pick] ? req_strb_i[pick*SW +: SW] : '0;
      end
      if (done || abort) begin
        rsp_valid_o[gnt] <= 1'b1;
        rsp_slverr_o     <= abort | pslverr_i;
        rsp_rdata_o      <= (done && !pwrite_o) ? prdata_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed and randomized checks of apb_master_arbiter against a protocol model.
// Timeout section follows APB_ARB_TIMEOUT_EN.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_slverr, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;
  logic [SW-1:0]   pstrb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_master_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .arst_i(arst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_slverr_o(rsp_slverr),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[k]         = w;
    req_addr[k*AW +: AW] = a;
    req_wdata[k*DW +: DW] = d;
    req_strb[k*SW +: SW] = s;
  endtask

  task automatic do_reset;
    arst      = 1'b1;
    req_valid = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    repeat (2) @(posedge clk);
    #2;
    arst = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } txn_t;

  logic [31:0] mem [16];

  initial begin
    int mptr, last, got, want, acc, ph, cur, waitc, rsp_idx;
    logic stuck, rsp_exp, rsp_e;
    logic [31:0] rsp_d;
    logic [N-1:0] drop;
    txn_t ct;

    arst = 1'b1;
    req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    req_valid = '1;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);

    // zero-wait write
    do_reset;
    pready = 1'b1;
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
    req_valid = 4'b0001;
    #1;
    chk("zw_ready", req_ready, 4'b0001);
    chk("zw_psel_T", psel, 0);
    cyc; req_valid = '0; #1;
    chk("zw_psel_T1", psel, 1);
    chk("zw_pen_T1", penable, 0);
    chk("zw_paddr", paddr, 32'h10);
    chk("zw_pwdata", pwdata, 32'hA5A5_0001);
    chk("zw_pstrb", pstrb, 4'hF);
    chk("zw_pwrite", pwrite, 1);
    cyc; #1;
    chk("zw_psel_T2", psel, 1);
    chk("zw_pen_T2", penable, 1);
    cyc; #1;
    chk("zw_rsp", rsp_valid, 4'b0001);
    chk("zw_slverr", rsp_slverr, 0);
    chk("zw_rdata", rsp_rdata, 0);
    chk("zw_psel_T3", psel, 0);
    cyc; #1;
    chk("zw_rsp_once", rsp_valid, 0);

    // round-robin fairness with all requesters held valid
    do_reset;
    pready = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 32'(k * 4), 32'h0, 4'h0);
    req_valid = '1;
    mptr = 0; last = -1; got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (c != 0) cyc;
      #1;
      if (req_ready != '0) begin
        want = rr_pick(req_valid, mptr);
        chk("rr_grant", req_ready, onehot(want));
        if (last >= 0) chk("rr_gap", c - last, 3);
        last = c;
        mptr = (want + 1) % N;
        got++;
      end
    end
    chk("rr_count", got, 5);
    req_valid = '0;
    repeat (4) cyc;

    // wait states, slave error, stable APB outputs
    do_reset;
    pready = 1'b0;
    set_req(1, 1'b0, 32'h08, 32'h1234, 4'hF);
    req_valid = 4'b0010;
    #1;
    chk("ws_ready", req_ready, 4'b0010);
    cyc;
    set_req(0, 1'b1, 32'h40, 32'h1, 4'h1);
    set_req(2, 1'b1, 32'h44, 32'h2, 4'h2);
    req_valid = 4'b0101;
    #1;
    chk("ws_setup_pen", penable, 0);
    for (int i = 0; i < 4; i++) begin
      cyc; #1;
      chk("ws_pen", penable, 1);
      chk("ws_paddr", paddr, 32'h08);
      chk("ws_pwrite", pwrite, 0);
      chk("ws_pwdata", pwdata, 32'h1234);
      chk("ws_pstrb", pstrb, 0);
      chk("ws_ready_busy", req_ready, 0);
      chk("ws_no_rsp", rsp_valid, 0);
    end
    cyc;
    pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
    #1;
    chk("ws_last_access", penable, 1);
    cyc;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #1;
    chk("ws_rsp", rsp_valid, 4'b0010);
    chk("ws_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("ws_slverr", rsp_slverr, 1);
    chk("ws_psel_gap", psel, 0);
    chk("ws_next_grant", req_ready, 4'b0100);
    cyc; req_valid = '0; pready = 1'b1;
    repeat (4) cyc;

    // reset in the middle of ACCESS
    do_reset;
    pready = 1'b0;
    set_req(2, 1'b0, 32'h0C, 32'h0, 4'h0);
    req_valid = 4'b0100;
    #1;
    chk("ra_ready", req_ready, 4'b0100);
    cyc; req_valid = '0;
    cyc; #1;
    chk("ra_access", penable, 1);
    #1; arst = 1'b1; #1;
    chk("ra_psel", psel, 0);
    chk("ra_pen", penable, 0);
    chk("ra_rsp", rsp_valid, 0);
    pready = 1'b1;
    @(posedge clk); #2;
    arst = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 32'h0, 32'h0, 4'h0);
    req_valid = '1;
    #1;
    chk("ra_ptr0", req_ready, 4'b0001);
    cyc; req_valid = '0; #1;
    chk("ra_discard", rsp_valid, 0);
    repeat (4) cyc;

`ifdef APB_ARB_TIMEOUT_EN
    do_reset;
    pready = 1'b0; prdata = 32'hFFFF_FFFF;
    set_req(3, 1'b0, 32'h20, 32'h0, 4'h0);
    req_valid = 4'b1000;
    #1;
    chk("to_ready", req_ready, 4'b1000);
    cyc; req_valid = '0;
    acc = 0; got = 0;
    for (int c = 0; c < 30; c++) begin
      cyc; #1;
      if (penable) acc++;
      if (rsp_valid != '0) begin
        got = 1;
        chk("to_rsp", rsp_valid, 4'b1000);
        chk("to_slverr", rsp_slverr, 1);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_psel", psel, 0);
        break;
      end
    end
    chk("to_seen", got, 1);
    chk("to_access_cycles", acc, TO);
    pready = 1'b1;
    set_req(0, 1'b1, 32'h24, 32'h5, 4'h3);
    req_valid = 4'b0001;
    #1;
    chk("to_next_ready", req_ready, 4'b0001);
    cyc; req_valid = '0;
    cyc; cyc; #1;
    chk("to_next_rsp", rsp_valid, 4'b0001);
    chk("to_next_err", rsp_slverr, 0);
`else
    do_reset;
    pready = 1'b0;
    set_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
    req_valid = 4'b0001;
    #1;
    chk("nt_ready", req_ready, 4'b0001);
    cyc; req_valid = '0;
    cyc;
    stuck = 1'b1;
    repeat (30) begin
      cyc; #1;
      if (!(psel && penable) || rsp_valid != '0) stuck = 1'b0;
    end
    chk("nt_waits", stuck, 1);
    pready = 1'b1; prdata = 32'h0BAD_F00D;
    cyc; pready = 1'b0; #1;
    chk("nt_rsp", rsp_valid, 4'b0001);
    chk("nt_rdata", rsp_rdata, 32'h0BAD_F00D);
`endif

    // randomized traffic against the protocol model
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    do_reset;
    mptr = 0; ph = 0; cur = 0; waitc = 0; rsp_idx = 0;
    rsp_exp = 1'b0; rsp_e = 1'b0; rsp_d = '0; drop = '0;
    ct = '{w: 1'b0, a: 32'h0, d: 32'h0, s: 4'h0};
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~drop;
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
          set_req(k, 1'($urandom_range(0, 1)),
                  ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2),
                  $urandom, 4'($urandom_range(0, 15)));
          req_valid[k] = 1'b1;
        end
      end
      if (psel && penable) begin
        pready  = (waitc >= 4) || ($urandom_range(0, 2) != 0);
        pslverr = ($urandom_range(0, 7) == 0);
        prdata  = pwrite ? $urandom : mem[paddr[5:2]];
      end else begin
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
      #2;
      chk("rnd_rsp_valid", rsp_valid, rsp_exp ? onehot(rsp_idx) : '0);
      if (rsp_exp) begin
        chk("rnd_rdata", rsp_rdata, rsp_d);
        chk("rnd_slverr", rsp_slverr, rsp_e);
      end
      rsp_exp = 1'b0;
      chk("rnd_psel", psel, ph != 0);
      chk("rnd_penable", penable, ph == 2);
      if (ph != 0) begin
        chk("rnd_paddr", paddr, ct.a);
        chk("rnd_pwrite", pwrite, ct.w);
        chk("rnd_pwdata", pwdata, ct.d);
        chk("rnd_pstrb", pstrb, ct.w ? ct.s : 4'h0);
      end
      chk("rnd_ready", req_ready,
          (ph == 0 && req_valid != '0) ? onehot(rr_pick(req_valid, mptr)) : '0);
      drop = '0;
      if (ph == 2) begin
        if (pready) begin
          rsp_exp = 1'b1;
          rsp_idx = cur;
          rsp_e   = pslverr;
          rsp_d   = ct.w ? 32'h0 : mem[ct.a[5:2]];
          if (ct.w)
            for (int b = 0; b < SW; b++)
              if (ct.s[b]) mem[ct.a[5:2]][8*b +: 8] = ct.d[8*b +: 8];
          ph = 0;
          waitc = 0;
        end else begin
          waitc++;
        end
      end else if (ph == 1) begin
        ph = 2;
      end else if (req_valid != '0) begin
        cur  = rr_pick(req_valid, mptr);
        mptr = (cur + 1) % N;
        ct.w = req_write[cur];
        ct.a = req_addr[cur*AW +: AW];
        ct.d = req_wdata[cur*DW +: DW];
        ct.s = req_strb[cur*SW +: SW];
        drop[cur] = 1'b1;
        ph = 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
